// File: rtl/led_fade_pkg.sv
// rtl/led_fade_pkg.sv - shared types and level-step helper for the LED fade driver
package led_fade_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FADING = 1'b1
  } state_t;

  // Wide enough for PWM_BITS up to 16 with headroom for the un-clamped sum
  localparam int LVL_W = 17;
  typedef logic [LVL_W-1:0] lvl_wide_t;

  // One saturating fade step of lvl toward tgt; never wraps past 0 or maxl
  function automatic lvl_wide_t step_level(input lvl_wide_t lvl,
                                           input lvl_wide_t tgt,
                                           input lvl_wide_t step,
                                           input lvl_wide_t maxl);
    lvl_wide_t sum;
    sum = lvl + step;
    if (lvl < tgt) begin
      step_level = (sum > maxl) ? maxl : sum;
    end else if (lvl > tgt) begin
      step_level = (lvl > step) ? (lvl - step) : '0;
    end else begin
      step_level = lvl;
    end
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// rtl/led_fade_driver_if.sv - pattern word valid/ready handshake bundle
interface led_fade_driver_if #(
  parameter int LEDS_NR = 8
);
  logic               pat_valid;
  logic [LEDS_NR-1:0] pat_data;
  logic               pat_ready;

  modport master (output pat_valid, pat_data, input pat_ready);
  modport slave  (input pat_valid, pat_data, output pat_ready);
endinterface

// File: rtl/led_fade_channel.sv
// rtl/led_fade_channel.sv - one LED channel: level/target registers, fade step, PWM compare
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                load_on,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                on,
  output logic                at_target,
  output logic                differs_new
);

  typedef logic [PWM_BITS-1:0] lvl_t;
  localparam lvl_t MAXL = '1;

  lvl_t level;
  logic tgt_on;
  lvl_t tgt;

  // Targets are only ever 0 or MAXL, so one bit is enough to hold T
  assign tgt = tgt_on ? MAXL : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level  <= '0;
      tgt_on <= 1'b0;
    end else begin
      if (load) begin
        tgt_on <= load_on;
      end
      if (tick) begin
        level <= lvl_t'(step_level(lvl_wide_t'(level), lvl_wide_t'(tgt),
                                   lvl_wide_t'(FADE_STEP), lvl_wide_t'(MAXL)));
      end
    end
  end

  assign at_target   = (level == tgt);
  assign differs_new = (level != (load_on ? MAXL : lvl_t'(0)));
  assign on          = (level == MAXL) | (pwm_cnt < level);

endmodule

// File: rtl/led_fade_driver.sv
// rtl/led_fade_driver.sv - pattern-driven PWM LED driver with smooth fade between patterns
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int LEDS_NR    = 8,
  parameter int PWM_BITS   = 8,
  parameter int FADE_STEP  = 16,
  parameter int FADE_DIV   = 24000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  led_fade_driver_if.slave   bus,
  output logic               busy,
  output logic [LEDS_NR-1:0] led
);

  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(FADE_DIV - 1);
  localparam logic [LEDS_NR-1:0] LED_OFF = ACTIVE_LOW ? '1 : '0;

  state_t              state;
  state_t              state_nxt;
  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                ready;
  logic                xfer;
  logic                tick;
  logic [LEDS_NR-1:0]  on;
  logic [LEDS_NR-1:0]  at_target;
  logic [LEDS_NR-1:0]  differs_new;

  assign ready         = (state == IDLE);
  assign bus.pat_ready = ready;
  assign busy          = (state == FADING);
  assign xfer          = bus.pat_valid & ready;
  assign tick          = (state == FADING) && (presc == '0);

  genvar g;
  generate
    for (g = 0; g < LEDS_NR; g++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS  (PWM_BITS),
        .FADE_STEP (FADE_STEP)
      ) u_ch (
        .clk         (clk),
        .resetn      (resetn),
        .load        (xfer),
        .load_on     (bus.pat_data[g]),
        .tick        (tick),
        .pwm_cnt     (pwm_cnt),
        .on          (on[g]),
        .at_target   (at_target[g]),
        .differs_new (differs_new[g])
      );
    end
  endgenerate

  // A pattern equal to the current levels is accepted without leaving IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && (|differs_new)) state_nxt = FADING;
      FADING:  if (&at_target) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc <= PRE_RELOAD;
    end else if (xfer) begin
      presc <= PRE_RELOAD;
    end else if (state == FADING) begin
      presc <= (presc == '0) ? PRE_RELOAD : (presc - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      led     <= LED_OFF;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led     <= ACTIVE_LOW ? ~on : on;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// tb/tb_led_fade_driver.sv - self-checking bench for led_fade_driver
module tb_led_fade_driver;

  localparam int MAXL = 15;
  localparam int STEP = 5;
  localparam int DIV  = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy;
  logic [7:0] led;
  int         n_cmp = 0;
  int         n_fail = 0;

  led_fade_driver_if #(.LEDS_NR(8)) bus ();

  led_fade_driver #(
    .LEDS_NR(8), .PWM_BITS(4), .FADE_STEP(STEP), .FADE_DIV(DIV), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .led(led)
  );

  always #5 clk = ~clk;

  // Behavioural reference: integer levels/targets, a tick countdown and a PWM phase
  int         m_lvl[8];
  int         m_tgt[8];
  bit         m_fading = 1'b0;
  int         m_cd = DIV - 1;
  int         m_pwm = 0;
  logic [7:0] m_led = 8'hFF;
  int         m_accept_cnt = 0;

  function automatic int fade(int l, int t);
    if (l < t) return (l + STEP > MAXL) ? MAXL : l + STEP;
    if (l > t) return (l - STEP < 0) ? 0 : l - STEP;
    return l;
  endfunction

  function automatic bit all_at();
    for (int i = 0; i < 8; i++) if (m_lvl[i] != m_tgt[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit differs(logic [7:0] d);
    for (int i = 0; i < 8; i++) if (m_lvl[i] != (d[i] ? MAXL : 0)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        m_lvl[i] <= 0;
        m_tgt[i] <= 0;
      end
      m_fading <= 1'b0;
      m_cd     <= DIV - 1;
      m_pwm    <= 0;
      m_led    <= 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++)
        m_led[i] <= !((m_lvl[i] == MAXL) || (m_pwm < m_lvl[i]));
      if (!m_fading) begin
        if (bus.pat_valid) begin
          for (int i = 0; i < 8; i++) m_tgt[i] <= bus.pat_data[i] ? MAXL : 0;
          m_cd         <= DIV - 1;
          m_fading     <= differs(bus.pat_data);
          m_accept_cnt <= m_accept_cnt + 1;
        end
      end else begin
        m_fading <= !all_at();
        if (m_cd == 0) begin
          for (int i = 0; i < 8; i++) m_lvl[i] <= fade(m_lvl[i], m_tgt[i]);
          m_cd <= DIV - 1;
        end else begin
          m_cd <= m_cd - 1;
        end
      end
      m_pwm <= (m_pwm + 1) % (MAXL + 1);
    end
  end

  task automatic test_reset();
    bus.pat_valid = 1'b0;
    bus.pat_data  = 8'h00;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({led, bus.pat_ready, busy} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_held: led=%h ready=%b busy=%b want led=ff ready=1 busy=0", led, bus.pat_ready, busy);
    end
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({led, bus.pat_ready, busy} !== {8'hFF, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: led=%h ready=%b busy=%b want led=ff ready=1 busy=0", k, led, bus.pat_ready, busy);
      end
    end
  endtask

  task automatic test_fade_in();
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 8'h01;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      bus.pat_valid = 1'b0;
      n_cmp++;
      if (bus.pat_ready !== (k >= 13) || busy !== (k <= 12)) begin
        n_fail++;
        $display("FAIL fade_in_fsm k=%0d: ready=%b busy=%b want ready=%b busy=%b", k, bus.pat_ready, busy, k >= 13, k <= 12);
      end
      n_cmp++;
      if (led !== m_led || (k >= 13 && led !== 8'hFE)) begin
        n_fail++;
        $display("FAIL fade_in_led k=%0d: led=%h want %h", k, led, (k >= 13) ? 8'hFE : m_led);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 8'h03;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      bus.pat_data = 8'h80;
      if (k == 14) bus.pat_valid = 1'b0;
      n_cmp++;
      if (bus.pat_ready !== (k == 13 || k >= 27) || busy !== !(k == 13 || k >= 27)) begin
        n_fail++;
        $display("FAIL backpressure_fsm k=%0d: ready=%b busy=%b want ready=%b", k, bus.pat_ready, busy, (k == 13 || k >= 27));
      end
      n_cmp++;
      if (led !== m_led || (k >= 27 && led !== 8'h7F)) begin
        n_fail++;
        $display("FAIL backpressure_led k=%0d: led=%h want %h", k, led, (k >= 27) ? 8'h7F : m_led);
      end
    end
  endtask

  task automatic test_noop();
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 8'h80;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.pat_valid = 1'b0;
      n_cmp++;
      if ({led, bus.pat_ready, busy} !== {8'h7F, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL noop k=%0d: led=%h ready=%b busy=%b want led=7f ready=1 busy=0", k, led, bus.pat_ready, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.pat_valid = 1'b1;
    bus.pat_data  = 8'h55;
    @(negedge clk);
    bus.pat_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({led, bus.pat_ready, busy} !== {8'hFF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_immediate: led=%h ready=%b busy=%b want led=ff ready=1 busy=0", led, bus.pat_ready, busy);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({led, bus.pat_ready, busy} !== {8'hFF, 1'b1, 1'b0} || led !== m_led) begin
        n_fail++;
        $display("FAIL async_reset_after k=%0d: led=%h ready=%b busy=%b want led=ff ready=1 busy=0", k, led, bus.pat_ready, busy);
      end
    end
  endtask

  task automatic test_random();
    int seen;
    seen = m_accept_cnt;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({led, bus.pat_ready, busy} !== {m_led, !m_fading, m_fading}) begin
        n_fail++;
        $display("FAIL random k=%0d: led=%h ready=%b busy=%b want led=%h ready=%b busy=%b",
                 k, led, bus.pat_ready, busy, m_led, !m_fading, m_fading);
      end
      if (bus.pat_valid) begin
        if (m_accept_cnt != seen) bus.pat_valid = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.pat_valid = 1'b1;
        bus.pat_data  = 8'($urandom);
        seen = m_accept_cnt;
      end
    end
    bus.pat_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_backpressure();
    test_noop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
